// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port program/data RAM between the CPU
// fetch/execute path and the program loader. An owner FSM grants one
// requester at a time with a burst limit. The loader can lock the RAM to hold
// the CPU off. Read data is routed back to whichever requester issued the read.
module mem_arbiter #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_lock,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // The burst counter needs at least one bit, even when HOLD_MAX is 1.
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_LD   = 2'd2
    } rd_own_t;

    owner_t        owner;
    owner_t        owner_nxt;
    owner_t        last_own;
    owner_t        last_own_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    rd_own_t       rd_own;
    rd_own_t       rd_own_nxt;
    logic          cpu_want;

    // The lock masks the CPU request when the next owner is chosen.
    assign cpu_want = cpu_req & ~ld_lock;

    // State register. Reset biases the first tie toward the CPU and drops any read that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= OWN_IDLE;
            cnt      <= '0;
            last_own <= OWN_LD;
            rd_own   <= RD_NONE;
        end else begin
            owner    <= owner_nxt;
            cnt      <= cnt_nxt;
            last_own <= last_own_nxt;
            rd_own   <= rd_own_nxt;
        end
    end

    // Issue path: the current owner's command reaches the RAM while it requests. The lock suppresses any CPU issue.
    always_comb begin
        cpu_gnt    = 1'b0;
        ld_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_own_nxt = RD_NONE;
        if ((owner == OWN_CPU) && cpu_req && !ld_lock) begin
            cpu_gnt   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
                rd_own_nxt = RD_CPU;
            end else begin
                rd_own_nxt = RD_NONE;
            end
        end else if ((owner == OWN_LD) && ld_req) begin
            ld_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            if (!ld_we) begin
                rd_own_nxt = RD_LD;
            end else begin
                rd_own_nxt = RD_NONE;
            end
        end else begin
            rd_own_nxt = RD_NONE;
        end
    end

    // Next owner: the lock preempts, IDLE breaks ties against the last owner, and a busy owner yields after HOLD_MAX grants.
    always_comb begin
        owner_nxt = owner;
        cnt_nxt   = cnt;
        if (ld_lock) begin
            owner_nxt = ld_req ? OWN_LD : OWN_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (owner)
                OWN_IDLE: begin
                    cnt_nxt = '0;
                    if (cpu_want && ld_req) begin
                        owner_nxt = (last_own == OWN_CPU) ? OWN_LD : OWN_CPU;
                    end else if (cpu_want) begin
                        owner_nxt = OWN_CPU;
                    end else if (ld_req) begin
                        owner_nxt = OWN_LD;
                    end else begin
                        owner_nxt = OWN_IDLE;
                    end
                end
                OWN_CPU: begin
                    if (cpu_req) begin
                        if (ld_req && (cnt == CNT_MAX)) begin
                            owner_nxt = OWN_LD;
                            cnt_nxt   = '0;
                        end else if (cnt == CNT_MAX) begin
                            cnt_nxt = cnt;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        owner_nxt = ld_req ? OWN_LD : OWN_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                OWN_LD: begin
                    if (ld_req) begin
                        if (cpu_want && (cnt == CNT_MAX)) begin
                            owner_nxt = OWN_CPU;
                            cnt_nxt   = '0;
                        end else if (cnt == CNT_MAX) begin
                            cnt_nxt = cnt;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end else begin
                        owner_nxt = cpu_want ? OWN_CPU : OWN_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    owner_nxt = OWN_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // The tie-break memory follows every non-idle owner.
    always_comb begin
        if (owner_nxt != OWN_IDLE) begin
            last_own_nxt = owner_nxt;
        end else begin
            last_own_nxt = last_own;
        end
    end

    // Read return: RAM data goes only to the requester that issued the read and is zero otherwise.
    always_comb begin
        cpu_rvalid = (rd_own == RD_CPU);
        ld_rvalid  = (rd_own == RD_LD);
        if (rd_own == RD_CPU) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = '0;
        end
        if (rd_own == RD_LD) begin
            ld_rdata = mem_rdata;
        end else begin
            ld_rdata = '0;
        end
    end

    // Stall whenever the CPU waits. Reset forces it low so that every output is quiet during reset.
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural arbitration and RAM model.
module tb_mem_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_we, ld_req, ld_we, ld_lock;
    logic [3:0] cpu_addr, ld_addr;
    logic [7:0] cpu_wdata, ld_wdata;
    logic       cpu_gnt, cpu_rvalid, cpu_stall, ld_gnt, ld_rvalid;
    logic [7:0] cpu_rdata, ld_rdata;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] ram [16];

    int checks = 0;
    int failures = 0;

    // Model state: owner 0=idle 1=cpu 2=loader; rd 0=none 1=cpu 2=loader
    int         m_owner, m_cnt, m_last, m_rd;
    logic [7:0] m_rd_data;
    logic [7:0] mmem [16];

    logic       obs_cg, obs_lg, obs_crv, obs_st;
    logic [7:0] obs_crd;
    logic [7:0] rd_log [$];

    mem_arbiter #(.AW(4), .DW(8), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: synchronous read, write committed at the edge
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_last = 2; m_rd = 0;
    endtask

    // One clock cycle: entered at posedge+1 with inputs set, checks mid-cycle, advances the model at the edge
    task automatic cycle();
        logic e_cg, e_lg, e_en, e_we, e_crv, e_lrv, e_st;
        logic [3:0] e_addr;
        logic [7:0] e_wd, e_crd, e_lrd;
        int mine, other, nxt;
        #3;
        if (rst) model_reset();
        e_cg = !rst && m_owner == 1 && cpu_req && !ld_lock;
        e_lg = !rst && m_owner == 2 && ld_req;
        e_en = e_cg || e_lg;
        e_we = e_cg ? cpu_we : (e_lg ? ld_we : 1'b0);
        e_addr = e_cg ? cpu_addr : (e_lg ? ld_addr : 4'h0);
        e_wd = e_cg ? cpu_wdata : (e_lg ? ld_wdata : 8'h00);
        e_crv = (m_rd == 1);
        e_lrv = (m_rd == 2);
        e_crd = e_crv ? m_rd_data : 8'h00;
        e_lrd = e_lrv ? m_rd_data : 8'h00;
        e_st = cpu_req && !e_cg && !rst;
        check("cpu_gnt", cpu_gnt, e_cg);
        check("ld_gnt", ld_gnt, e_lg);
        check("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {e_en, e_we, e_addr, e_wd});
        check("cpu_rvalid", cpu_rvalid, e_crv);
        check("cpu_rdata", cpu_rdata, e_crd);
        check("ld_rvalid", ld_rvalid, e_lrv);
        check("ld_rdata", ld_rdata, e_lrd);
        check("cpu_stall", cpu_stall, e_st);
        obs_cg = cpu_gnt; obs_lg = ld_gnt; obs_crv = cpu_rvalid; obs_crd = cpu_rdata; obs_st = cpu_stall;
        if (cpu_rvalid) rd_log.push_back(cpu_rdata);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_rd = 0;
            if (e_cg) begin
                if (cpu_we) mmem[cpu_addr] = cpu_wdata;
                else begin m_rd = 1; m_rd_data = mmem[cpu_addr]; end
            end
            if (e_lg) begin
                if (ld_we) mmem[ld_addr] = ld_wdata;
                else begin m_rd = 2; m_rd_data = mmem[ld_addr]; end
            end
            // Ownership decision from who wants the RAM and how long the owner has held it
            if (ld_lock) begin
                nxt = ld_req ? 2 : 0;
                m_cnt = 0;
            end else if (m_owner == 0) begin
                if (cpu_req && ld_req) nxt = 3 - m_last;
                else if (cpu_req)      nxt = 1;
                else if (ld_req)       nxt = 2;
                else                   nxt = 0;
                m_cnt = 0;
            end else begin
                mine  = (m_owner == 1) ? int'(cpu_req) : int'(ld_req);
                other = (m_owner == 1) ? int'(ld_req) : int'(cpu_req);
                if (mine != 0 && other != 0 && m_cnt == HOLD - 1) begin
                    nxt = 3 - m_owner; m_cnt = 0;
                end else if (mine != 0) begin
                    nxt = m_owner;
                    m_cnt = (m_cnt + 1 > HOLD - 1) ? HOLD - 1 : m_cnt + 1;
                end else begin
                    nxt = (other != 0) ? 3 - m_owner : 0;
                    m_cnt = 0;
                end
            end
            m_owner = nxt;
            if (nxt != 0) m_last = nxt;
        end
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [3:0] a, input logic [7:0] d);
        logic done = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = obs_cg;
        end
        check("cpu_grant_timeout", done, 1'b1);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic ld_access(input logic we, input logic [3:0] a, input logic [7:0] d);
        logic done = 1'b0;
        ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            done = obs_lg;
        end
        check("ld_grant_timeout", done, 1'b1);
        ld_req = 1'b0; ld_we = 1'b0;
    endtask

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 37 + 11);
        if (i == 3) v = 8'h5A;
        return v;
    endfunction

    initial begin
        logic [12:0] pat_c, pat_l, pat_s;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 8'h00;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 4'h0; ld_wdata = 8'h00; ld_lock = 1'b0;
        for (int i = 0; i < 16; i++) mmem[i] = 8'h00;
        model_reset();
        @(posedge clk); #1;
        cycle();
        check("reset_outs", {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;

        // Loader fills the RAM with a known pattern (RAM[3]=5A)
        for (int i = 0; i < 16; i++) ld_access(1'b1, 4'(i), init_val(i));
        cycle(); cycle();

        // Both request continuously: CPU x4, LD x4, CPU x4
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h1;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'h2;
        pat_c = '0; pat_l = '0; pat_s = '0;
        for (int k = 0; k < 13; k++) begin
            cycle();
            pat_c = {pat_c[11:0], obs_cg};
            pat_l = {pat_l[11:0], obs_lg};
            pat_s = {pat_s[11:0], obs_st};
        end
        check("t3_cpu_pattern", pat_c, 13'b0111100001111);
        check("t3_ld_pattern", pat_l, 13'b0000011110000);
        check("t3_stall_pattern", pat_s, 13'b1000011110000);
        cpu_req = 1'b0; ld_req = 1'b0;
        cycle(); cycle(); cycle();

        // CPU read of address 3 from IDLE
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
        cycle();
        check("t2_no_gnt_n", obs_cg, 1'b0);
        cycle();
        check("t2_gnt_n1", obs_cg, 1'b1);
        cpu_req = 1'b0;
        cycle();
        check("t2_rvalid_n2", obs_crv, 1'b1);
        check("t2_rdata", obs_crd, 8'h5A);
        cycle(); cycle();

        // Lock arrives while the CPU owns the RAM at cnt=1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h0;
        cycle(); cycle();
        ld_lock = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'h1;
        cycle();
        check("t4_cpu_blocked", obs_cg, 1'b0);
        check("t4_stall", obs_st, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t4_ld_owns", {obs_lg, obs_cg, obs_st}, 3'b101);
        end
        ld_lock = 1'b0; ld_req = 1'b0;
        cycle(); cycle();
        check("t4_cpu_back", obs_cg, 1'b1);
        cpu_req = 1'b0;
        cycle(); cycle();

        // Locked load of 0..15, then CPU reads everything back
        ld_lock = 1'b1;
        for (int i = 0; i < 16; i++) ld_access(1'b1, 4'(i), 8'(i));
        ld_lock = 1'b0;
        cycle();
        rd_log.delete();
        for (int i = 0; i < 16; i++) cpu_access(1'b0, 4'(i), 8'h00);
        cycle();
        check("t5_count", rd_log.size(), 16);
        for (int i = 0; i < 16 && i < rd_log.size(); i++) check("t5_rdata", rd_log[i], 8'(i));
        cycle();

        // Reset in the cycle after a granted CPU read
        cpu_access(1'b0, 4'h5, 8'h00);
        rst = 1'b1;
        cycle();
        check("t6_no_rvalid", obs_crv, 1'b0);
        rst = 1'b0;
        cpu_access(1'b0, 4'h5, 8'h00);
        cycle();
        check("t6_reissue_rvalid", obs_crv, 1'b1);
        check("t6_reissue_rdata", obs_crd, 8'h05);

        // Reset pulse while both request, then the first tie goes to the CPU
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h7;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 4'h8;
        cycle(); cycle();
        rst = 1'b1;
        #1;
        check("t1_outs_zero", {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, cpu_stall, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, ld_rdata}, 64'd0);
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        check("t1_tie_cpu", {obs_cg, obs_lg}, 2'b10);

        // Randomized traffic with lock episodes
        for (int k = 0; k < 1500; k++) begin
            cycle();
            if (obs_cg || !cpu_req) begin
                cpu_req = ($urandom_range(0, 2) != 0);
                cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 4'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom_range(0, 255));
            end
            if (obs_lg || !ld_req) begin
                ld_req = ($urandom_range(0, 2) == 0);
                ld_we = 1'($urandom_range(0, 1));
                ld_addr = 4'($urandom_range(0, 15));
                ld_wdata = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 24) == 0) ld_lock = ~ld_lock;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
